if_prefetch: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue. It generates the fetch PC, drives a synchronous instruction ROM, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. The FIFO feeds the IF/ID boundary and absorbs ID-side stalls without losing fetches. It also accepts a PC redirect that flushes all buffered and in-flight fetches, which is the hook for branch and jump support.

---
 rtl/if_prefetch.sv | 116 +++++++++++
 tb/tb_if_prefetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: generates the fetch PC, drives a synchronous ROM and
// buffers returned {pc, inst} pairs in a DEPTH-entry prefetch queue for ID.
module if_prefetch #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              id_stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [DATA_W-1:0] inst_mem_q [DEPTH];

    logic              pop;
    logic              push;
    logic              issue;
    logic [OCC_W-1:0]  occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit check counts the in-flight word so a return never hits a full queue;
    // the stall input reaches rom_ce_o only through pop, one AND gate deep.
    always_comb begin
        pop   = id_valid_o & ~id_stall_i;
        push  = inflight_q & ~redirect_i & ~rst;
        occ   = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
        issue = ~rst & ~redirect_i & (occ < OCC_W'(DEPTH));
    end

    assign rom_ce_o   = issue;
    assign rom_addr_o = fetch_pc_q;
    assign id_valid_o = (count_q != '0);
    assign id_pc_o    = pc_mem_q[rd_ptr_q];
    assign id_inst_o  = inst_mem_q[rd_ptr_q];

    // Next-state: redirect flushes queue and in-flight fetch, overriding push/pop/issue.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            inflight_d = 1'b0;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Queue storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
            inst_mem_q[wr_ptr_q] <= rom_data_i;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: DEPTH=4 instance for the scenarios, plus a
// DEPTH=3 instance streamed with random stalls to exercise pointer wrap.
module tb_if_prefetch;

    logic        clk;
    logic        rst;
    logic [31:0] rom_data;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;

    logic [31:0] rom_data3;
    logic        rom_ce3;
    logic [31:0] rom_addr3;
    logic        stall3;
    logic        valid3;
    logic [31:0] pc3;
    logic [31:0] inst3;

    int compared;
    int mismatched;

    if_prefetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rom_data_i(rom_data), .rom_ce_o(rom_ce),
        .rom_addr_o(rom_addr), .id_stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .id_valid_o(valid), .id_pc_o(pc), .id_inst_o(inst)
    );

    if_prefetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(3), .RESET_PC(32'h0)) dut3 (
        .clk(clk), .rst(rst), .rom_data_i(rom_data3), .rom_ce_o(rom_ce3),
        .rom_addr_o(rom_addr3), .id_stall_i(stall3), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .id_valid_o(valid3), .id_pc_o(pc3), .id_inst_o(inst3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM models: word = address ^ 0xA5A5_0000
    always @(posedge clk) begin
        if (rom_ce)  rom_data  <= rom_addr  ^ 32'hA5A5_0000;
        if (rom_ce3) rom_data3 <= rom_addr3 ^ 32'hA5A5_0000;
    end

    // Overflow watch: a push into a full queue without a simultaneous pop
    always @(negedge clk) begin
        #2;
        if (!rst && !redirect) begin
            compared++;
            if (dut.inflight_q && int'(dut.count_q) == 4 && !(valid && !stall)) begin
                mismatched++;
                $display("FAIL overflow4: push into full queue, count %0d required <4", dut.count_q);
            end
            compared++;
            if (dut3.inflight_q && int'(dut3.count_q) == 3 && !(valid3 && !stall3)) begin
                mismatched++;
                $display("FAIL overflow3: push into full queue, count %0d required <3", dut3.count_q);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; stall3 = 1'b0; redirect = 1'b0; redirect_pc = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_stream();
        logic [31:0] exp_pc;
        do_reset();
        #1;
        compared++; if (rom_ce !== 1'b0) begin mismatched++; $display("FAIL rst_ce: got %b need 0", rom_ce); end
        compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b need 0", valid); end
        compared++; if (rom_addr !== 32'h0) begin mismatched++; $display("FAIL rst_addr: got %h need 0", rom_addr); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); rst = 1'b0; #1;
            compared++; if (rom_ce !== 1'b1) begin mismatched++; $display("FAIL stream_ce[%0d]: got %b need 1", i, rom_ce); end
            if (i < 2) begin
                compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL stream_valid[%0d]: got %b need 0", i, valid); end
            end else begin
                exp_pc = 32'((i - 2) * 4);
                compared++; if (valid !== 1'b1) begin mismatched++; $display("FAIL stream_valid[%0d]: got %b need 1", i, valid); end
                compared++; if (pc !== exp_pc) begin mismatched++; $display("FAIL stream_pc[%0d]: got %h need %h", i, pc, exp_pc); end
                compared++; if (inst !== (exp_pc ^ 32'hA5A5_0000)) begin mismatched++; $display("FAIL stream_inst[%0d]: got %h need %h", i, inst, exp_pc ^ 32'hA5A5_0000); end
            end
            if (i == 0) begin
                compared++; if (rom_addr !== 32'h0) begin mismatched++; $display("FAIL stream_addr0: got %h need 0", rom_addr); end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic        exp_ce;
        logic [31:0] exp_pc;
        do_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk); stall = (i < 8); #1;
            exp_ce = (i < 2) || (i >= 8);
            exp_pc = (i < 8) ? 32'h0 : 32'((i - 8) * 4);
            compared++; if (rom_ce !== exp_ce) begin mismatched++; $display("FAIL bp_ce[%0d]: got %b need %b", i, rom_ce, exp_ce); end
            compared++; if (valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid[%0d]: got %b need 1", i, valid); end
            compared++; if (pc !== exp_pc) begin mismatched++; $display("FAIL bp_pc[%0d]: got %h need %h", i, pc, exp_pc); end
            if (i == 3) begin
                compared++; if (int'(dut.count_q) != 4) begin mismatched++; $display("FAIL bp_count: got %0d need 4", dut.count_q); end
            end
            if (i == 8) begin
                compared++; if (rom_addr !== 32'h10) begin mismatched++; $display("FAIL bp_addr: got %h need 10", rom_addr); end
            end
        end
        @(negedge clk); stall = 1'b0;
    endtask

    task automatic test_redirect_full();
        logic [31:0] exp_pc;
        do_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); stall = 1'b1;
        end
        @(negedge clk); stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h100; #1;
        compared++; if (int'(dut.count_q) != 4) begin mismatched++; $display("FAIL rf_full: got %0d need 4", dut.count_q); end
        compared++; if (rom_ce !== 1'b0) begin mismatched++; $display("FAIL rf_ce_T: got %b need 0", rom_ce); end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); redirect = 1'b0; redirect_pc = 32'hDEAD_0000; #1;
            if (i <= 2) begin
                compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL rf_valid[T+%0d]: got %b need 0", i, valid); end
            end else begin
                exp_pc = 32'h100 + 32'((i - 3) * 4);
                compared++; if (valid !== 1'b1) begin mismatched++; $display("FAIL rf_valid[T+%0d]: got %b need 1", i, valid); end
                compared++; if (pc !== exp_pc) begin mismatched++; $display("FAIL rf_pc[T+%0d]: got %h need %h", i, pc, exp_pc); end
            end
            if (i == 1) begin
                compared++; if (rom_addr !== 32'h100) begin mismatched++; $display("FAIL rf_addr: got %h need 100", rom_addr); end
            end
        end
    endtask

    task automatic test_redirect_return();
        logic [31:0] exp_pc;
        do_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        @(negedge clk); redirect = 1'b1; redirect_pc = 32'h200; #1;
        compared++; if (valid !== 1'b1 || pc !== 32'h0) begin mismatched++; $display("FAIL rr_head: got %b/%h need 1/0", valid, pc); end
        compared++; if (rom_ce !== 1'b0) begin mismatched++; $display("FAIL rr_ce_T: got %b need 0", rom_ce); end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); redirect = 1'b0; #1;
            if (i <= 2) begin
                compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL rr_valid[T+%0d]: got %b need 0", i, valid); end
            end else begin
                exp_pc = 32'h200 + 32'((i - 3) * 4);
                compared++; if (valid !== 1'b1) begin mismatched++; $display("FAIL rr_valid[T+%0d]: got %b need 1", i, valid); end
                compared++; if (pc !== exp_pc) begin mismatched++; $display("FAIL rr_pc[T+%0d]: got %h need %h", i, pc, exp_pc); end
            end
            if (i == 1) begin
                compared++; if (rom_ce !== 1'b1 || rom_addr !== 32'h200) begin mismatched++; $display("FAIL rr_issue: got %b/%h need 1/200", rom_ce, rom_addr); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pcs [4];
        exp_pcs[0] = 32'hFFFF_FFF8; exp_pcs[1] = 32'hFFFF_FFFC;
        exp_pcs[2] = 32'h0000_0000; exp_pcs[3] = 32'h0000_0004;
        do_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        @(negedge clk); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk); redirect = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            compared++; if (valid !== 1'b1) begin mismatched++; $display("FAIL wrap_valid[%0d]: got %b need 1", i, valid); end
            compared++; if (pc !== exp_pcs[i]) begin mismatched++; $display("FAIL wrap_pc[%0d]: got %h need %h", i, pc, exp_pcs[i]); end
            compared++; if (inst !== (exp_pcs[i] ^ 32'hA5A5_0000)) begin mismatched++; $display("FAIL wrap_inst[%0d]: got %h need %h", i, inst, exp_pcs[i] ^ 32'hA5A5_0000); end
        end
    endtask

    task automatic test_depth3_wrap();
        logic [31:0] exp_pc;
        int          pops;
        exp_pc = 32'h0;
        pops   = 0;
        do_reset();
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 200 && pops < 14; i++) begin
            @(negedge clk); stall3 = 1'($urandom_range(0, 1)); #1;
            if (valid3 && !stall3) begin
                compared++; if (pc3 !== exp_pc || inst3 !== (exp_pc ^ 32'hA5A5_0000)) begin
                    mismatched++; $display("FAIL d3_pop[%0d]: got %h/%h need %h/%h", pops, pc3, inst3, exp_pc, exp_pc ^ 32'hA5A5_0000);
                end
                exp_pc = exp_pc + 32'h4;
                pops++;
            end
        end
        compared++; if (pops < 10) begin mismatched++; $display("FAIL d3_progress: got %0d pops need >=10", pops); end
        @(negedge clk); stall3 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_pc;
        do_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        @(negedge clk); stall = 1'b1;
        @(negedge clk); stall = 1'b0; rst = 1'b1; #1;
        compared++; if (int'(dut.count_q) != 2) begin mismatched++; $display("FAIL rm_half: got %0d need 2", dut.count_q); end
        compared++; if (rom_ce !== 1'b0) begin mismatched++; $display("FAIL rm_ce_rst: got %b need 0", rom_ce); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); rst = 1'b0; #1;
            compared++; if (rom_ce !== 1'b1) begin mismatched++; $display("FAIL rm_ce[%0d]: got %b need 1", i, rom_ce); end
            if (i == 0) begin
                compared++; if (rom_addr !== 32'h0) begin mismatched++; $display("FAIL rm_addr: got %h need 0", rom_addr); end
            end
            if (i < 2) begin
                compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL rm_valid[%0d]: got %b need 0", i, valid); end
            end else begin
                exp_pc = 32'((i - 2) * 4);
                compared++; if (valid !== 1'b1) begin mismatched++; $display("FAIL rm_valid[%0d]: got %b need 1", i, valid); end
                compared++; if (pc !== exp_pc) begin mismatched++; $display("FAIL rm_pc[%0d]: got %h need %h", i, pc, exp_pc); end
            end
        end
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        stall3      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        test_reset_stream();
        test_back_pressure();
        test_redirect_full();
        test_redirect_return();
        test_wrap();
        test_depth3_wrap();
        test_reset_mid();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
